// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares one uart_tx between NUM_REQ byte-stream requesters. A requester is
//   granted for a whole packet (through its req_last byte) and selection is
//   round-robin. uart_tx has no busy output, so an internal frame timer paces
//   successive start pulses.
// Ports
//   clk        system clock, posedge
//   rst_n      asynchronous active-low reset
//   req_valid  per-requester byte valid
//   req_data   packed bytes, requester i at [8i+7:8i]
//   req_last   per-requester end-of-packet marker, qualifies req_valid
//   req_ready  per-requester accept strobe (high only in SEND for the owner)
//   tx_start   one-cycle start pulse to uart_tx
//   tx_data    byte to uart_tx, held until the next load
//   grant      one-hot current owner, zero when no owner
//   busy       high in every state except IDLE
module uart_tx_arbiter #(
    parameter int CLOCK_FREQUENCY = 27000000,
    parameter int BAUD_RATE       = 115200,
    parameter int NUM_REQ         = 4,
    parameter int HOLD_TIMEOUT    = 1024
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [8*NUM_REQ-1:0]   req_data,
    input  logic [NUM_REQ-1:0]     req_last,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic                   tx_start,
    output logic [7:0]             tx_data,
    output logic [NUM_REQ-1:0]     grant,
    output logic                   busy
);

    // One 8N1 frame plus margin: 11 bit times absorbs baud-divider rounding.
    localparam int FRAME_CYCLES = 11 * (CLOCK_FREQUENCY / BAUD_RATE) + 2;
    localparam int FRAME_W      = $clog2(FRAME_CYCLES + 1);
    localparam int IDLE_W       = (HOLD_TIMEOUT > 0) ? $clog2(HOLD_TIMEOUT + 1) : 1;
    localparam int PTR_W        = $clog2(NUM_REQ);
    localparam bit HOLD_EN      = (HOLD_TIMEOUT > 0);

    localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(FRAME_CYCLES - 1);
    localparam logic [FRAME_W-1:0] FRAME_MAX  = {FRAME_W{1'b1}};
    localparam logic [IDLE_W-1:0]  IDLE_LAST  = IDLE_W'((HOLD_TIMEOUT > 0) ? HOLD_TIMEOUT - 1 : 0);
    localparam logic [IDLE_W-1:0]  IDLE_MAX   = {IDLE_W{1'b1}};
    localparam logic [PTR_W-1:0]   PTR_LAST   = PTR_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        ST_GUARD = 2'd0,
        ST_IDLE  = 2'd1,
        ST_SEND  = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    state_t               state_r;
    logic [FRAME_W-1:0]   frame_cnt_r;
    logic [IDLE_W-1:0]    idle_cnt_r;
    logic [PTR_W-1:0]     ptr_r;
    logic [PTR_W-1:0]     gidx_r;
    logic [NUM_REQ-1:0]   grant_r;
    logic                 last_q_r;
    logic                 tx_start_r;
    logic [7:0]           tx_data_r;
    logic                 busy_r;

    logic [PTR_W-1:0]     pick_idx_s;
    logic                 pick_found_s;
    logic [7:0]           sel_byte_s;
    logic                 sel_last_s;
    logic                 owner_valid_s;
    logic [PTR_W-1:0]     next_ptr_s;

    // Index 'off' places above 'base', wrapping at NUM_REQ.
    function automatic logic [PTR_W-1:0] rot_idx(input logic [PTR_W-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        return PTR_W'((sum >= NUM_REQ) ? sum - NUM_REQ : sum);
    endfunction

    // Round-robin pick: scan downward so the nearest valid index above the pointer wins.
    always_comb begin
        pick_idx_s = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            pick_idx_s = req_valid[rot_idx(ptr_r, k)] ? rot_idx(ptr_r, k) : pick_idx_s;
        end
    end

    // One-hot mux of the owner's byte and last flag.
    always_comb begin
        sel_byte_s = 8'h00;
        sel_last_s = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sel_byte_s = sel_byte_s | (req_data[8*i +: 8] & {8{grant_r[i]}});
            sel_last_s = sel_last_s | (req_last[i] & grant_r[i]);
        end
    end

    assign pick_found_s  = |req_valid;
    assign owner_valid_s = |(req_valid & grant_r);
    assign next_ptr_s    = (gidx_r == PTR_LAST) ? {PTR_W{1'b0}} : gidx_r + PTR_W'(1);

    // Arbitration and pacing FSM; every output except req_ready is registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_GUARD;
            frame_cnt_r <= '0;
            idle_cnt_r  <= '0;
            ptr_r       <= '0;
            gidx_r      <= '0;
            grant_r     <= '0;
            last_q_r    <= 1'b0;
            tx_start_r  <= 1'b0;
            tx_data_r   <= 8'h00;
            busy_r      <= 1'b1;
        end else begin
            tx_start_r <= 1'b0;
            case (state_r)
                ST_GUARD: begin
                    // The start cycle is the first guard cycle, so a frame is fully covered.
                    if (frame_cnt_r == FRAME_LAST) begin
                        frame_cnt_r <= '0;
                        if (grant_r == '0) begin
                            state_r <= ST_IDLE;
                            busy_r  <= 1'b0;
                        end else if (last_q_r) begin
                            grant_r  <= '0;
                            ptr_r    <= next_ptr_s;
                            last_q_r <= 1'b0;
                            state_r  <= ST_IDLE;
                            busy_r   <= 1'b0;
                        end else begin
                            idle_cnt_r <= '0;
                            state_r    <= ST_HOLD;
                        end
                    end else if (frame_cnt_r != FRAME_MAX) begin
                        frame_cnt_r <= frame_cnt_r + FRAME_W'(1);
                    end else begin
                        frame_cnt_r <= frame_cnt_r;
                    end
                end
                ST_IDLE: begin
                    if (pick_found_s) begin
                        gidx_r  <= pick_idx_s;
                        grant_r <= NUM_REQ'(1) << pick_idx_s;
                        state_r <= ST_SEND;
                        busy_r  <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_SEND: begin
                    tx_data_r   <= sel_byte_s;
                    last_q_r    <= sel_last_s;
                    tx_start_r  <= 1'b1;
                    frame_cnt_r <= '0;
                    state_r     <= ST_GUARD;
                end
                ST_HOLD: begin
                    // A dropped req_valid from the owner is simply idle time here.
                    if (owner_valid_s) begin
                        idle_cnt_r <= '0;
                        state_r    <= ST_SEND;
                    end else if (HOLD_EN && (idle_cnt_r == IDLE_LAST)) begin
                        idle_cnt_r <= '0;
                        grant_r    <= '0;
                        ptr_r      <= next_ptr_s;
                        last_q_r   <= 1'b0;
                        state_r    <= ST_IDLE;
                        busy_r     <= 1'b0;
                    end else if (idle_cnt_r != IDLE_MAX) begin
                        idle_cnt_r <= idle_cnt_r + IDLE_W'(1);
                    end else begin
                        idle_cnt_r <= idle_cnt_r;
                    end
                end
                default: begin
                    grant_r     <= '0;
                    frame_cnt_r <= '0;
                    state_r     <= ST_GUARD;
                    busy_r      <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready = grant_r & {NUM_REQ{state_r == ST_SEND}};
    assign tx_start  = tx_start_r;
    assign tx_data   = tx_data_r;
    assign grant     = grant_r;
    assign busy      = busy_r;

endmodule
